nes_controller_reader: RTL

//  Console-side reader for the NES controller block. Drives nes_latch / nes_clk / nes_en
//  and shifts in the controller's serial q output, one bit per serial clock.

---
 rtl/nes_controller_reader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/nes_controller_reader.sv
// Console-side NES pad reader: latches the pad, clocks out 8 serial bits and
// publishes the frame with a one-cycle valid strobe and a newly-pressed mask.
module nes_controller_reader #(
    parameter int HALF_PERIOD     = 4,
    parameter int POLL_PERIOD     = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int ACTIVE_LOW_DATA = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       nes_data_i,
    output logic       nes_latch_o,
    output logic       nes_clk_o,
    output logic       nes_en_o,
    output logic       busy_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic [7:0] pressed_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_BIT_LO = 3'd2,
        S_BIT_HI = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [2:0]             bit_q;
    logic [6:0]             shift_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PW-1:0]          poll_q;
    logic                   latch_q;
    logic                   nclk_q;
    logic                   busy_q;
    logic                   valid_q;
    logic [7:0]             buttons_q;
    logic [7:0]             pressed_q;

    logic       sample;
    logic       poll_tick;
    logic       trigger;
    logic [7:0] frame_d;

    assign sample    = sync_q[SYNC_STAGES-1] ^ (ACTIVE_LOW_DATA != 0);
    assign poll_tick = (POLL_PERIOD != 0) && en_i && (poll_q == POLL_LAST);
    assign trigger   = en_i && (start_i || poll_tick);
    // Bit 7 goes straight into the published frame so valid lands in DONE itself.
    assign frame_d   = {sample, shift_q};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= nes_data_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            poll_q <= '0;
        end else if ((POLL_PERIOD != 0) && en_i) begin
            poll_q <= (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            latch_q   <= 1'b0;
            nclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            valid_q   <= 1'b0;
            pressed_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q <= S_LATCH;
                        cnt_q   <= '0;
                        latch_q <= 1'b1;
                        nclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == LATCH_LAST) begin
                        state_q <= S_BIT_LO;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        latch_q <= 1'b0;
                        nclk_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == HALF_LAST) begin
                            nclk_q <= 1'b1;
                        end
                    end
                end
                S_BIT_LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q   <= S_DONE;
                            buttons_q <= frame_d;
                            pressed_q <= frame_d & ~buttons_q;
                            valid_q   <= 1'b1;
                        end else begin
                            shift_q[bit_q] <= sample;
                            state_q        <= S_BIT_HI;
                            nclk_q         <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BIT_HI: begin
                    if (cnt_q == HALF_LAST) begin
                        state_q <= S_BIT_LO;
                        cnt_q   <= '0;
                        nclk_q  <= 1'b0;
                        bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    latch_q <= 1'b0;
                    nclk_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nes_latch_o = latch_q;
    assign nes_clk_o   = nclk_q;
    assign nes_en_o    = busy_q;
    assign busy_o      = busy_q;
    assign buttons_o   = buttons_q;
    assign valid_o     = valid_q;
    assign pressed_o   = pressed_q;
    assign state_o     = state_q;
endmodule
